clint_timer: RTL and testbench

CLINT_TIMER -- requirements
Module: clint_timer

---
 rtl/clint_pkg.sv | 36 +++
 rtl/mtime_prescaler.sv | 27 ++
 rtl/clint_timer.sv | 111 +++++++++++
 tb/tb_clint_timer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared constants and address decode for the CLINT timer block.
package clint_pkg;

  localparam logic [4:0] ADDR_MSIP        = 5'h00;
  localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] ADDR_MTIME_LO    = 5'h0C;
  localparam logic [4:0] ADDR_MTIME_HI    = 5'h10;
  localparam logic [4:0] ADDR_WORD_MASK   = 5'h1C;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_MSIP    = 3'd0,
    REG_CMP_LO  = 3'd1,
    REG_CMP_HI  = 3'd2,
    REG_TIME_LO = 3'd3,
    REG_TIME_HI = 3'd4,
    REG_NONE    = 3'd7
  } reg_sel_e;

  // Byte-lane bits are masked off so misaligned addresses hit the containing word.
  function automatic reg_sel_e decode_addr(input logic [4:0] addr);
    logic [4:0] word_addr;
    word_addr = addr & ADDR_WORD_MASK;
    case (word_addr)
      ADDR_MSIP:        decode_addr = REG_MSIP;
      ADDR_MTIMECMP_LO: decode_addr = REG_CMP_LO;
      ADDR_MTIMECMP_HI: decode_addr = REG_CMP_HI;
      ADDR_MTIME_LO:    decode_addr = REG_TIME_LO;
      ADDR_MTIME_HI:    decode_addr = REG_TIME_HI;
      default:          decode_addr = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mtime_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tick_out is high in the cycle the count sits at PRESCALE-1.
module mtime_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign tick_out = (r_cnt == LAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt <= '0;
    end else if (tick_out) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Machine timer / software interrupt block: 64-bit mtime, mtimecmp and msip behind a
// single-cycle register bus.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [4:0]  addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] rdata_out,
  output logic        ack_out,
  output logic        t_irq_out,
  output logic        s_irq_out
);

  logic        w_tick;
  logic        w_wr;
  reg_sel_e    w_sel;
  logic [31:0] w_rdata;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_t_irq;

  mtime_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .tick_out (w_tick)
  );

  assign w_sel = decode_addr(addr_in);
  assign w_wr  = req_in & we_in;

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_MSIP:    w_rdata = {31'd0, r_msip};
      REG_CMP_LO:  w_rdata = r_mtimecmp[31:0];
      REG_CMP_HI:  w_rdata = r_mtimecmp[63:32];
      REG_TIME_LO: w_rdata = r_mtime[31:0];
      REG_TIME_HI: w_rdata = r_mtime[63:32];
      default:     w_rdata = '0;
    endcase
  end

  // Handshake: every cycle with req_in=1 is one access; ack_out rises the following
  // cycle with no stall, and rdata_out carries read data only while ack_out=1.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= req_in;
      r_rdata <= (req_in && !we_in) ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_msip <= 1'b0;
    end else if (w_wr && (w_sel == REG_MSIP)) begin
      r_msip <= wdata_in[0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_mtimecmp <= MTIMECMP_RESET;
    end else if (w_wr && (w_sel == REG_CMP_LO)) begin
      r_mtimecmp[31:0] <= wdata_in;
    end else if (w_wr && (w_sel == REG_CMP_HI)) begin
      r_mtimecmp[63:32] <= wdata_in;
    end
  end

  // A software write to either half wins over the tick; no carry into the other half.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_mtime <= '0;
    end else if (w_wr && (w_sel == REG_TIME_LO)) begin
      r_mtime[31:0] <= wdata_in;
    end else if (w_wr && (w_sel == REG_TIME_HI)) begin
      r_mtime[63:32] <= wdata_in;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_t_irq <= 1'b0;
    end else begin
      r_t_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign rdata_out = r_rdata;
  assign ack_out   = r_ack;
  assign t_irq_out = r_t_irq;
  assign s_irq_out = r_msip;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: one PRESCALE=4 and one PRESCALE=1 instance share the bus and are
// checked against a cycle-level behavioural model plus fixed scenario values.
module tb_clint_timer;
  import clint_pkg::*;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b0;
  logic        req_in   = 1'b0;
  logic        we_in    = 1'b0;
  logic [4:0]  addr_in  = '0;
  logic [31:0] wdata_in = '0;

  logic [1:0][31:0] rdata_o;
  logic [1:0]       ack_o;
  logic [1:0]       tirq_o;
  logic [1:0]       sirq_o;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  clint_timer #(.PRESCALE(4)) dut_p4 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_in    (req_in),
    .we_in     (we_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .rdata_out (rdata_o[0]),
    .ack_out   (ack_o[0]),
    .t_irq_out (tirq_o[0]),
    .s_irq_out (sirq_o[0])
  );

  clint_timer #(.PRESCALE(1)) dut_p1 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_in    (req_in),
    .we_in     (we_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .rdata_out (rdata_o[1]),
    .ack_out   (ack_o[1]),
    .t_irq_out (tirq_o[1]),
    .s_irq_out (sirq_o[1])
  );

  // ---------------- behavioural reference model ----------------
  // mtime is a plain 64-bit count of ticks; a tick happens on every PRESCALE-th edge
  // after reset release, derived from the edge count by modulo arithmetic.
  logic [63:0]      m_time [2];
  logic [63:0]      m_cmp  [2];
  logic [63:0]      m_edges[2];
  logic [1:0]       m_irq;
  logic [1:0][31:0] m_rdata;
  logic             m_ack;
  logic             m_msip;
  logic             m_tick;
  logic [31:0]      m_rd;
  logic [4:0]       m_word;

  function automatic int unsigned pre(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int d = 0; d < 2; d++) begin
        m_time[d]  = 64'd0;
        m_cmp[d]   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_edges[d] = 64'd0;
        m_irq[d]   = 1'b0;
        m_rdata[d] = 32'd0;
      end
      m_ack  = 1'b0;
      m_msip = 1'b0;
    end else begin
      m_word = addr_in & 5'h1C;
      for (int d = 0; d < 2; d++) begin
        m_irq[d] = (m_time[d] >= m_cmp[d]);
        m_rd = 32'd0;
        if (req_in && !we_in) begin
          case (m_word)
            ADDR_MSIP:        m_rd = {31'd0, m_msip};
            ADDR_MTIMECMP_LO: m_rd = m_cmp[d][31:0];
            ADDR_MTIMECMP_HI: m_rd = m_cmp[d][63:32];
            ADDR_MTIME_LO:    m_rd = m_time[d][31:0];
            ADDR_MTIME_HI:    m_rd = m_time[d][63:32];
            default:          m_rd = 32'd0;
          endcase
        end
        m_rdata[d] = m_rd;
      end
      m_ack = req_in;
      for (int d = 0; d < 2; d++) begin
        m_tick = ((m_edges[d] % 64'(pre(d))) == 64'(pre(d) - 1));
        m_edges[d] = m_edges[d] + 64'd1;
        if (req_in && we_in && m_word == ADDR_MTIME_LO)      m_time[d][31:0]  = wdata_in;
        else if (req_in && we_in && m_word == ADDR_MTIME_HI) m_time[d][63:32] = wdata_in;
        else if (m_tick)                                      m_time[d] = m_time[d] + 64'd1;
        if (req_in && we_in && m_word == ADDR_MTIMECMP_LO) m_cmp[d][31:0]  = wdata_in;
        if (req_in && we_in && m_word == ADDR_MTIMECMP_HI) m_cmp[d][63:32] = wdata_in;
      end
      if (req_in && we_in && m_word == ADDR_MSIP) m_msip = wdata_in[0];
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic drive(input logic req, input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata);
    req_in   = req;
    we_in    = we;
    addr_in  = addr;
    wdata_in = wdata;
    @(posedge clk_in);
    @(negedge clk_in);
    req_in = 1'b0;
    we_in  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (ack_o[d] !== 1'b0) $display("FAIL reset_ack dut%0d: got %b want 0", d, ack_o[d]);
      else n_pass++;
      n_total++;
      if (rdata_o[d] !== 32'd0) $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata_o[d]);
      else n_pass++;
      n_total++;
      if (tirq_o[d] !== 1'b0) $display("FAIL reset_tirq dut%0d: got %b want 0", d, tirq_o[d]);
      else n_pass++;
      n_total++;
      if (sirq_o[d] !== 1'b0) $display("FAIL reset_sirq dut%0d: got %b want 0", d, sirq_o[d]);
      else n_pass++;
    end
    rst_in = 1'b1;
  endtask

  task automatic test_prescale_idle;
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b0, 5'h00, 32'd0);
      for (int d = 0; d < 2; d++) begin
        n_total++;
        if (tirq_o[d] !== 1'b0) $display("FAIL idle_tirq dut%0d cyc%0d: got %b want 0", d, k, tirq_o[d]);
        else n_pass++;
      end
    end
    drive(1'b1, 1'b0, ADDR_MTIME_LO, 32'd0);
    n_total++;
    if (rdata_o[0] !== 32'd10) $display("FAIL idle_mtime_lo_p4: got %0d want 10", rdata_o[0]);
    else n_pass++;
    n_total++;
    if (rdata_o[1] !== 32'd40) $display("FAIL idle_mtime_lo_p1: got %0d want 40", rdata_o[1]);
    else n_pass++;
    drive(1'b1, 1'b0, ADDR_MTIME_HI, 32'd0);
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (rdata_o[d] !== 32'd0) $display("FAIL idle_mtime_hi dut%0d: got %h want 0", d, rdata_o[d]);
      else n_pass++;
    end
    drive(1'b1, 1'b0, ADDR_MTIMECMP_LO, 32'd0);
    n_total++;
    if (rdata_o[1] !== MTIMECMP_RESET[31:0]) $display("FAIL cmp_lo_reset: got %h want ffffffff", rdata_o[1]);
    else n_pass++;
    drive(1'b1, 1'b0, ADDR_MTIMECMP_HI, 32'd0);
    n_total++;
    if (rdata_o[0] !== MTIMECMP_RESET[63:32]) $display("FAIL cmp_hi_reset: got %h want ffffffff", rdata_o[0]);
    else n_pass++;
  endtask

  task automatic test_timer_irq;
    drive(1'b1, 1'b1, ADDR_MTIMECMP_HI, 32'd0);
    drive(1'b1, 1'b1, ADDR_MTIMECMP_LO, 32'd20);
    drive(1'b1, 1'b1, ADDR_MTIME_HI, 32'd0);
    drive(1'b1, 1'b1, ADDR_MTIME_LO, 32'd0);
    for (int k = 1; k <= 25; k++) begin
      drive(1'b0, 1'b0, 5'h00, 32'd0);
      n_total++;
      if (tirq_o[1] !== (k >= 21)) $display("FAIL irq_rise_p1 k%0d: got %b want %b", k, tirq_o[1], (k >= 21));
      else n_pass++;
      n_total++;
      if (tirq_o[0] !== m_irq[0]) $display("FAIL irq_rise_p4 k%0d: got %b want %b", k, tirq_o[0], m_irq[0]);
      else n_pass++;
    end
    drive(1'b1, 1'b1, ADDR_MTIMECMP_HI, 32'd1);
    n_total++;
    if (tirq_o[1] !== 1'b1) $display("FAIL irq_hold_after_write: got %b want 1", tirq_o[1]);
    else n_pass++;
    drive(1'b0, 1'b0, 5'h00, 32'd0);
    n_total++;
    if (tirq_o[1] !== 1'b0) $display("FAIL irq_drop: got %b want 0", tirq_o[1]);
    else n_pass++;
  endtask

  task automatic test_wrap;
    logic [31:0] exp_p1 [4];
    logic [4:0]  rd_addr [4];
    exp_p1[0] = 32'hFFFF_FFFE; exp_p1[1] = 32'hFFFF_FFFF; exp_p1[2] = 32'd0; exp_p1[3] = 32'd0;
    rd_addr[0] = ADDR_MTIME_LO; rd_addr[1] = ADDR_MTIME_HI;
    rd_addr[2] = ADDR_MTIME_LO; rd_addr[3] = ADDR_MTIME_HI;
    drive(1'b1, 1'b1, ADDR_MTIME_HI, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, ADDR_MTIME_LO, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, rd_addr[i], 32'd0);
      n_total++;
      if (rdata_o[1] !== exp_p1[i]) $display("FAIL wrap_p1 step%0d: got %h want %h", i, rdata_o[1], exp_p1[i]);
      else n_pass++;
      n_total++;
      if (rdata_o[0] !== m_rdata[0]) $display("FAIL wrap_p4 step%0d: got %h want %h", i, rdata_o[0], m_rdata[0]);
      else n_pass++;
      n_total++;
      if (tirq_o !== m_irq) $display("FAIL wrap_tirq step%0d: got %b want %b", i, tirq_o, m_irq);
      else n_pass++;
    end
  endtask

  task automatic test_msip;
    drive(1'b1, 1'b1, ADDR_MSIP, 32'hFFFF_FFFF);
    n_total++;
    if (sirq_o !== 2'b11) $display("FAIL msip_set: got %b want 11", sirq_o);
    else n_pass++;
    drive(1'b1, 1'b0, ADDR_MSIP, 32'd0);
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (rdata_o[d] !== 32'd1) $display("FAIL msip_read dut%0d: got %h want 1", d, rdata_o[d]);
      else n_pass++;
    end
    drive(1'b1, 1'b1, ADDR_MSIP, 32'd0);
    n_total++;
    if (sirq_o !== 2'b00) $display("FAIL msip_clear: got %b want 00", sirq_o);
    else n_pass++;
  endtask

  task automatic test_tick_write;
    drive(1'b1, 1'b1, ADDR_MTIME_LO, 32'h100);
    drive(1'b1, 1'b0, ADDR_MTIME_LO, 32'd0);
    n_total++;
    if (rdata_o[1] !== 32'h100) $display("FAIL tick_write_p1: got %h want 100", rdata_o[1]);
    else n_pass++;
    n_total++;
    if (rdata_o[0] !== m_rdata[0]) $display("FAIL tick_write_p4: got %h want %h", rdata_o[0], m_rdata[0]);
    else n_pass++;
  endtask

  task automatic test_unmapped;
    drive(1'b1, 1'b0, 5'h14, 32'd0);
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (ack_o[d] !== 1'b1 || rdata_o[d] !== 32'd0)
        $display("FAIL unmapped_read dut%0d: got ack=%b rdata=%h want ack=1 rdata=0", d, ack_o[d], rdata_o[d]);
      else n_pass++;
    end
    drive(1'b1, 1'b1, 5'h18, 32'hFFFF_FFFF);
    n_total++;
    if (ack_o !== 2'b11) $display("FAIL unmapped_write_ack: got %b want 11", ack_o);
    else n_pass++;
    drive(1'b0, 1'b0, 5'h00, 32'd0);
    n_total++;
    if (ack_o !== 2'b00 || rdata_o[1] !== 32'd0)
      $display("FAIL idle_no_ack: got ack=%b rdata=%h want ack=00 rdata=0", ack_o, rdata_o[1]);
    else n_pass++;
    drive(1'b1, 1'b0, ADDR_MTIMECMP_LO, 32'd0);
    n_total++;
    if (rdata_o[1] !== 32'd20) $display("FAIL unmapped_cmp_lo: got %h want 14", rdata_o[1]);
    else n_pass++;
    drive(1'b1, 1'b0, ADDR_MTIMECMP_HI, 32'd0);
    n_total++;
    if (rdata_o[1] !== 32'd1) $display("FAIL unmapped_cmp_hi: got %h want 1", rdata_o[1]);
    else n_pass++;
    drive(1'b1, 1'b0, ADDR_MSIP, 32'd0);
    n_total++;
    if (rdata_o[1] !== 32'd0) $display("FAIL unmapped_msip: got %h want 0", rdata_o[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access;
    drive(1'b1, 1'b1, ADDR_MSIP, 32'd1);
    drive(1'b1, 1'b0, ADDR_MTIMECMP_LO, 32'd0);
    req_in   = 1'b1;
    we_in    = 1'b1;
    addr_in  = ADDR_MTIMECMP_LO;
    wdata_in = 32'd5;
    #2;
    rst_in = 1'b0;
    #1;
    n_total++;
    if (ack_o !== 2'b00 || tirq_o !== 2'b00 || sirq_o !== 2'b00 || rdata_o !== '0)
      $display("FAIL reset_immediate: got ack=%b tirq=%b sirq=%b rdata=%h want all 0",
               ack_o, tirq_o, sirq_o, rdata_o);
    else n_pass++;
    @(posedge clk_in);
    @(negedge clk_in);
    n_total++;
    if (ack_o !== 2'b00) $display("FAIL reset_abort_ack: got %b want 00", ack_o);
    else n_pass++;
    req_in = 1'b0;
    we_in  = 1'b0;
    rst_in = 1'b1;
    drive(1'b1, 1'b0, ADDR_MTIMECMP_LO, 32'd0);
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (rdata_o[d] !== 32'hFFFF_FFFF) $display("FAIL reset_abort_cmp dut%0d: got %h want ffffffff", d, rdata_o[d]);
      else n_pass++;
    end
    drive(1'b1, 1'b0, ADDR_MTIME_LO, 32'd0);
    n_total++;
    if (rdata_o[1] !== 32'd1) $display("FAIL reset_first_tick_p1: got %0d want 1", rdata_o[1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [4:0] addrs [7];
    logic [4:0] a;
    logic [31:0] w;
    addrs[0] = 5'h00; addrs[1] = 5'h04; addrs[2] = 5'h08; addrs[3] = 5'h0C;
    addrs[4] = 5'h10; addrs[5] = 5'h14; addrs[6] = 5'h18;
    for (int i = 0; i < 300; i++) begin
      a = addrs[$urandom_range(0, 6)] | 5'($urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, w);
      for (int d = 0; d < 2; d++) begin
        n_total++;
        if (ack_o[d] !== m_ack) $display("FAIL rnd_ack dut%0d i%0d: got %b want %b", d, i, ack_o[d], m_ack);
        else n_pass++;
        n_total++;
        if (rdata_o[d] !== m_rdata[d]) $display("FAIL rnd_rdata dut%0d i%0d: got %h want %h", d, i, rdata_o[d], m_rdata[d]);
        else n_pass++;
        n_total++;
        if (tirq_o[d] !== m_irq[d]) $display("FAIL rnd_tirq dut%0d i%0d: got %b want %b", d, i, tirq_o[d], m_irq[d]);
        else n_pass++;
        n_total++;
        if (sirq_o[d] !== m_msip) $display("FAIL rnd_sirq dut%0d i%0d: got %b want %b", d, i, sirq_o[d], m_msip);
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk_in);
    test_reset;
    test_prescale_idle;
    test_timer_irq;
    test_wrap;
    test_msip;
    test_tick_write;
    test_unmapped;
    test_reset_mid_access;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
